// File: rtl/bch_pkg.sv
// Shared types, constants and GF(16) helpers for the BCH(15,7) t=2 decoder.
// Field is GF(2^4) generated by x^4+x+1; addition is XOR.
package bch_pkg;

    localparam int N = 15;
    localparam int K = 7;
    localparam int M = 4;

    localparam logic [4:0] GF_POLY = 5'b10011;

    typedef logic [3:0] gf_t;

    localparam gf_t ALPHA      = 4'b0010;
    localparam gf_t ALPHA3     = 4'b1000;
    localparam gf_t ALPHA_INV  = 4'b1001;
    localparam gf_t ALPHA_INV2 = 4'b1101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYND,
        ST_KES,
        ST_CHIEN,
        ST_DONE
    } state_t;

    // Carry-less multiply followed by reduction modulo GF_POLY.
    function automatic gf_t gf_mul(input gf_t a, input gf_t b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ (7'(a) << i);
        end
        for (int i = 6; i >= 4; i--) begin
            if (p[i]) p = p ^ (7'(GF_POLY) << (i - 4));
        end
        return p[3:0];
    endfunction

endpackage

// File: rtl/bch_cbm_block.sv
// Error-locator coefficients for a t=2 BCH code from S1, S2, S3.
// lambda1 = S1, lambda2 = S3/S1 + S2 (zero when S1 is zero).
module bch_cbm_block
    import bch_pkg::*;
(
    input  gf_t i_s1,
    input  gf_t i_s2,
    input  gf_t i_s3,
    output gf_t o_lam1,
    output gf_t o_lam2
);

    // Inverse as x^14 = x^8 * x^4 * x^2.
    function automatic gf_t gf_inv(input gf_t x);
        gf_t x2;
        gf_t x4;
        gf_t x8;
        x2 = gf_mul(x, x);
        x4 = gf_mul(x2, x2);
        x8 = gf_mul(x4, x4);
        return gf_mul(gf_mul(x8, x4), x2);
    endfunction

    gf_t w_inv_s1;

    assign w_inv_s1 = gf_inv(i_s1);
    assign o_lam1   = i_s1;
    assign o_lam2   = (i_s1 == 4'd0) ? 4'd0
                    : (gf_mul(i_s3, w_inv_s1) ^ i_s2);

endmodule

// File: rtl/bch_chien_step.sv
// One Chien search position per enabled cycle.
// Holds lambda1*a^-i and lambda2*a^-2i; flags a root when they sum to 1.
module bch_chien_step
    import bch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    input  gf_t  i_lam1,
    input  gf_t  i_lam2,
    output logic o_root
);

    gf_t r_t1;
    gf_t r_t2;
    gf_t w_t1_nxt;
    gf_t w_t2_nxt;

    gf_multiplier u_mul_t1 (
        .i_a (r_t1),
        .i_b (ALPHA_INV),
        .o_p (w_t1_nxt)
    );

    gf_multiplier u_mul_t2 (
        .i_a (r_t2),
        .i_b (ALPHA_INV2),
        .o_p (w_t2_nxt)
    );

    assign o_root = ((4'b0001 ^ r_t1 ^ r_t2) == 4'b0000);

    // Load the locator terms, then step them to the next position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t1 <= '0;
            r_t2 <= '0;
        end else if (i_load) begin
            r_t1 <= i_lam1;
            r_t2 <= i_lam2;
        end else if (i_en) begin
            r_t1 <= w_t1_nxt;
            r_t2 <= w_t2_nxt;
        end
    end

endmodule

// File: rtl/gf_multiplier.sv
// Combinational GF(16) multiplier, x^4+x+1 reduction.
// Thin wrapper around the package multiply so it can be instanced.
module gf_multiplier
    import bch_pkg::*;
(
    input  gf_t i_a,
    input  gf_t i_b,
    output gf_t o_p
);

    assign o_p = gf_mul(i_a, i_b);

endmodule

// File: rtl/bch_decode_ctrl.sv
// BCH(15,7) t=2 decode sequencer: serial syndromes, locator, Chien search.
// Define BCH_EARLY_EXIT_EN to skip KES/CHIEN for zero-syndrome words.
module bch_decode_ctrl #(
    parameter int N = 15,
    parameter int K = 7,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_codeword,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_codeword,
    output logic [K-1:0] out_msg,
    output logic [1:0]   out_nerr,
    output logic         out_fail,
    output logic         busy
);

    import bch_pkg::*;

    if (N != 15) begin : g_bad_n
        $error("bch_decode_ctrl supports only N = 15");
    end
    if (K != 7 || M != 4) begin : g_bad_km
        $error("bch_decode_ctrl supports only K = 7, M = 4");
    end

    state_t       r_state;
    state_t       w_next;
    logic [N-1:0] r_rx;
    gf_t          r_s1;
    gf_t          r_s3;
    logic [3:0]   r_cnt;
    logic [N-1:0] r_mask;
    logic [1:0]   r_root_cnt;
    logic [1:0]   r_exp_deg;
    logic         r_kes_fail;
    logic         r_in_ready;
    logic         r_busy;
    logic         r_out_valid;
    logic [N-1:0] r_out_cw;
    logic [1:0]   r_out_nerr;
    logic         r_out_fail;

    gf_t  w_s1a;
    gf_t  w_s3a;
    gf_t  w_s2;
    gf_t  w_s1cube;
    gf_t  w_s1_nxt;
    gf_t  w_s3_nxt;
    gf_t  w_lam1;
    gf_t  w_lam2;
    logic w_rbit;
    logic w_root;
    logic w_load;
    logic w_en;
    logic w_fail;

    gf_multiplier u_mul_s1 (
        .i_a (r_s1),
        .i_b (ALPHA),
        .o_p (w_s1a)
    );

    gf_multiplier u_mul_s3 (
        .i_a (r_s3),
        .i_b (ALPHA3),
        .o_p (w_s3a)
    );

    gf_multiplier u_mul_sq (
        .i_a (r_s1),
        .i_b (r_s1),
        .o_p (w_s2)
    );

    gf_multiplier u_mul_cube (
        .i_a (w_s2),
        .i_b (r_s1),
        .o_p (w_s1cube)
    );

    bch_cbm_block u_cbm (
        .i_s1   (r_s1),
        .i_s2   (w_s2),
        .i_s3   (r_s3),
        .o_lam1 (w_lam1),
        .o_lam2 (w_lam2)
    );

    bch_chien_step u_chien (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_en   (w_en),
        .i_lam1 (w_lam1),
        .i_lam2 (w_lam2),
        .o_root (w_root)
    );

    assign w_rbit   = r_rx[r_cnt];
    assign w_s1_nxt = w_s1a ^ {3'b000, w_rbit};
    assign w_s3_nxt = w_s3a ^ {3'b000, w_rbit};
    assign w_fail   = r_kes_fail || (r_root_cnt != r_exp_deg);

    // Next state and Chien control strobes.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_en   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (in_valid && r_in_ready) w_next = ST_SYND;
            end
            ST_SYND: begin
                if (r_cnt == 4'd0) begin
`ifdef BCH_EARLY_EXIT_EN
                    if (w_s1_nxt == 4'd0 && w_s3_nxt == 4'd0)
                        w_next = ST_DONE;
                    else
                        w_next = ST_KES;
`else
                    w_next = ST_KES;
`endif
                end
            end
            ST_KES: begin
                w_load = 1'b1;
                w_next = ST_CHIEN;
            end
            ST_CHIEN: begin
                w_en = 1'b1;
                if (r_cnt == 4'd14) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (r_out_valid && out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register plus registered handshake/status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == ST_IDLE);
            r_busy     <= (w_next != ST_IDLE);
        end
    end

    // Datapath: syndromes, classification, error mask and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx        <= '0;
            r_s1        <= '0;
            r_s3        <= '0;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_root_cnt  <= '0;
            r_exp_deg   <= '0;
            r_kes_fail  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_cw    <= '0;
            r_out_nerr  <= '0;
            r_out_fail  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_rx       <= in_codeword;
                        r_s1       <= '0;
                        r_s3       <= '0;
                        r_cnt      <= 4'd14;
                        r_mask     <= '0;
                        r_root_cnt <= '0;
                        r_exp_deg  <= '0;
                        r_kes_fail <= 1'b0;
                    end
                end
                ST_SYND: begin
                    r_s1  <= w_s1_nxt;
                    r_s3  <= w_s3_nxt;
                    r_cnt <= r_cnt - 4'd1;
                end
                ST_KES: begin
                    r_cnt      <= 4'd0;
                    r_mask     <= '0;
                    r_root_cnt <= '0;
                    if (r_s1 == 4'd0) begin
                        r_exp_deg  <= 2'd0;
                        r_kes_fail <= (r_s3 != 4'd0);
                    end else if (r_s3 == w_s1cube) begin
                        r_exp_deg  <= 2'd1;
                        r_kes_fail <= 1'b0;
                    end else begin
                        r_exp_deg  <= 2'd2;
                        r_kes_fail <= 1'b0;
                    end
                end
                ST_CHIEN: begin
                    if (w_root) begin
                        r_mask[r_cnt] <= ~r_mask[r_cnt];
                        r_root_cnt    <= r_root_cnt + 2'd1;
                    end
                    r_cnt <= r_cnt + 4'd1;
                end
                ST_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        if (w_fail) begin
                            r_out_cw   <= r_rx;
                            r_out_nerr <= 2'd3;
                            r_out_fail <= 1'b1;
                        end else begin
                            r_out_cw   <= r_rx ^ r_mask;
                            r_out_nerr <= r_root_cnt;
                            r_out_fail <= 1'b0;
                        end
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign busy         = r_busy;
    assign out_valid    = r_out_valid;
    assign out_codeword = r_out_cw;
    assign out_msg      = r_out_cw[N-1:N-K];
    assign out_nerr     = r_out_nerr;
    assign out_fail     = r_out_fail;

endmodule

// File: doc/bch_decode_ctrl.md
Name: bch_decode_ctrl

Overview:
- Sequencer for the BCH(15,7), t=2 decoder over GF(16), primitive polynomial x^4+x+1.
- Accepts one received codeword per transaction and computes the syndromes S1, S2, S3 serially.
- Launches the existing error-locator block (bch_cbm_block, which supplies lambda1/lambda2), then runs a serial Chien search and returns the corrected codeword with status.
- Sits between the channel-side input buffer and the message sink; both sides use valid/ready.

Parameters:
- N, 15, codeword length. Only 15 is supported; an elaboration-time check fails for any other value.
- K, 7, message length. Message occupies codeword bits [14:8] (systematic).
- M, 4, GF symbol width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  received codeword valid.
- in_ready  out  1  high only in IDLE.
- in_codeword  in  N  received word; bit i is the coefficient of x^i.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  sink accepts the result.
- out_codeword  out  N  corrected word; the raw word on failure.
- out_msg  out  K  out_codeword[14:8].
- out_nerr  out  2  errors corrected, 0..2; 3 on failure.
- out_fail  out  1  uncorrectable.
- busy  out  1  state != IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs 0 while rst is high, including in_ready; in_ready rises on the first clk edge after release.
  - Internal registers are cleared.
  - Reset mid-operation discards the transaction; no partial result is ever presented.
- States: IDLE, SYND, KES, CHIEN, DONE. All outputs are registered.
- IDLE:
  - When in_valid & in_ready, latch in_codeword into rx_reg, clear S1/S3 and the bit counter, and go to SYND.
- SYND (15 cycles), Horner recursion MSB first, bit j = 14 down to 0:
  - S1 <= S1*alpha ^ r_j.
  - S3 <= S3*alpha^3 ^ r_j.
  - S2 = S1^2, computed combinationally.
  - The 4-bit counter goes from 14 to 0; exit to KES on count 0.
- KES (1 cycle): register lambda1/lambda2 from bch_cbm_block and classify expected_deg:
  - S1==0 and S3==0: 0.
  - S1!=0 and S3==S1^3: 1.
  - S1!=0 otherwise: 2.
  - S1==0 and S3!=0: fail.
- CHIEN (15 cycles), position i = 0..14:
  - t1 initialised to lambda1, t2 to lambda2.
  - Each cycle: if (1 ^ t1 ^ t2)==0, toggle err_mask[i] and increment root_cnt.
  - Then t1 <= t1*alpha^-1 (4'b1001) and t2 <= t2*alpha^-2 (4'b1101).
- DONE:
  - Fail condition: KES flagged fail, or root_cnt != expected_deg.
  - On fail: out_codeword = rx_reg, out_nerr = 3, out_fail = 1.
  - Otherwise: out_codeword = rx_reg ^ err_mask, out_nerr = root_cnt, out_fail = 0.
  - out_valid rises exactly 32 clk edges after the accepting edge.
  - Outputs stay stable while out_ready is low.
  - On out_valid & out_ready, go to IDLE. in_ready is 1 on the next cycle; there is no same-cycle turnaround.
- GF arithmetic:
  - Multiply is polynomial multiply mod x^4+x+1; add is XOR.
  - Constants come from the shared package.

Optional Feature:
- Macro: BCH_EARLY_EXIT_EN.
- Defined: if S1==0 and S3==0 at SYND exit, skip KES and CHIEN and go straight to DONE.
  - out_codeword = rx_reg, nerr = 0.
  - Latency 16 edges.
- Undefined: fixed latency of 32 for every codeword.

Decomposition:
- bch_pkg holds:
  - N, K, M.
  - GF_POLY = 5'b10011.
  - ALPHA = 4'b0010, ALPHA3 = 4'b1000, ALPHA_INV = 4'b1001, ALPHA_INV2 = 4'b1101.
  - typedef gf_t (logic [3:0]).
  - The state enum.
  - function gf_mul.
- Instantiates existing bch_cbm_block and gf_multiplier.
- One new sub-module, bch_chien_step: t1/t2 registers, root detect, load/enable.

Test Plan:
- 15'h0000 -> out_codeword 15'h0000, msg 7'h00, nerr 0, fail 0; out_valid at edge 32 (16 with BCH_EARLY_EXIT_EN).
- 15'h01D9 (codeword 15'h01D1 with bit 3 flipped) -> out_codeword 15'h01D1, msg 7'h01, nerr 1, fail 0.
- 15'h41D0 (15'h01D1 with bits 14 and 0 flipped) -> out_codeword 15'h01D1, nerr 2, fail 0.
- 15'h0013 (S1=0, S3=4'b0110) -> fail 1, nerr 3, out_codeword 15'h0013.
- Backpressure: out_ready held low for 10 cycles after out_valid -> outputs stable, in_ready 0, a second in_valid is ignored; after the handshake, in_ready is 1 on the next cycle.
- Reset pulse during CHIEN -> all outputs 0 immediately; no out_valid. A fresh 15'h01D9 then decodes to 15'h01D1 with normal latency.
